div_sequencer: RTL

Multi-cycle sequencer for the RV32M divide/remainder instructions (DIV, DIVU, REM, REMU), sitting beside the EX-stage ALU. Divide ops are recognised in EX and handed to this block. It runs a 32-iteration radix-2 restoring divider with its own operand, partial-remainder and quotient registers. It holds the pipeline via `stall` until the result is ready. Divide-by-zero and signed overflow are resolved in one cycle without iterating.

---
 rtl/div_sequencer.sv | 84 ++++++++
 1 files changed

// File: rtl/div_sequencer.sv
// div_sequencer: multi-cycle RV32M DIV/DIVU/REM/REMU sequencer (radix-2 restoring)
// that holds the pipeline via stall until the quotient or remainder is ready.
module div_sequencer (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  func3,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  logic        flush,
    output logic        stall,
    output logic        busy,
    output logic        done,
    output logic [31:0] result
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t state, next_state;
    logic [31:0] dvd, dvs, rem, abs_a, abs_b, q_fin, r_fin;
    logic [32:0] rem_sh, diff;
    logic [4:0]  count;
    logic        neg_q, neg_r, is_rem, acc, sgn, div_zero, ovf;
    assign acc      = start & func3[2] & ~flush;
    assign sgn      = ~func3[0];
    assign div_zero = (op_b == '0);
    assign ovf      = sgn & (op_a == 32'h8000_0000) & (op_b == '1);
    assign abs_a    = (sgn & op_a[31]) ? -op_a : op_a;
    assign abs_b    = (sgn & op_b[31]) ? -op_b : op_b;
    // The dividend register doubles as the quotient: bits shift out the top as quotient bits shift in.
    assign rem_sh   = {rem, dvd[31]};
    assign diff     = rem_sh - {1'b0, dvs};
    assign q_fin    = {dvd[30:0], ~diff[32]};
    assign r_fin    = diff[32] ? rem_sh[31:0] : diff[31:0];
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= next_state;
            busy  <= next_state != IDLE;
            done  <= next_state == DONE;
        end
    end
    always_comb begin
        next_state = flush ? IDLE :
                     state == IDLE ? (acc ? ((div_zero | ovf) ? DONE : CALC) : IDLE) :
                     state == CALC ? ((count == 5'd31) ? DONE : CALC) : IDLE;
    end
    always_comb begin
        stall = ~rst & ~flush & (((state == IDLE) & start & func3[2]) | (state == CALC));
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            dvd    <= '0;
            dvs    <= '0;
            rem    <= '0;
            count  <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            is_rem <= 1'b0;
            result <= '0;
        end else if (state == IDLE && acc) begin
            if (div_zero) begin
                result <= func3[1] ? op_a : '1;
            end else if (ovf) begin
                result <= func3[1] ? '0 : 32'h8000_0000;
            end else begin
                dvd    <= abs_a;
                dvs    <= abs_b;
                rem    <= '0;
                count  <= '0;
                neg_q  <= sgn & (op_a[31] ^ op_b[31]);
                neg_r  <= sgn & op_a[31];
                is_rem <= func3[1];
            end
        end else if (state == CALC && !flush) begin
            rem   <= r_fin;
            dvd   <= q_fin;
            count <= count + 5'd1;
            if (count == 5'd31)
                result <= is_rem ? (neg_r ? -r_fin : r_fin) : (neg_q ? -q_fin : q_fin);
        end
    end
endmodule
